// File: rtl/axis_pkt_fifo.sv
// Packet-aware AXIS FIFO with optional store-and-forward gating.
// Sits behind the delay unit, absorbs its bursts and reports fill level
// and the number of complete packets held.
module axis_pkt_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned STORE_FWD  = 1
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [DATA_WIDTH-1:0] axis_m_tdata,
    input  logic [KEEP_WIDTH-1:0] axis_m_tkeep,
    input  logic                  axis_m_tlast,
    input  logic                  axis_m_tvalid,
    output logic                  axis_m_tready,
    output logic [DATA_WIDTH-1:0] axis_s_tdata,
    output logic [KEEP_WIDTH-1:0] axis_s_tkeep,
    output logic                  axis_s_tlast,
    output logic                  axis_s_tvalid,
    input  logic                  axis_s_tready,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned WORD_W = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int unsigned DEPTH_WORDS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LVL_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [WORD_W-1:0]     mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [ADDR_WIDTH:0]   pkt_count_q, pkt_count_d;
    logic                  active_q, active_d;   // head packet partly delivered
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;

    logic                  wr_en, rd_en;
    logic                  pkt_inc, pkt_dec;
    logic [WORD_W-1:0]     rd_word;

    // Handshakes and next-state for level, packet count and output flags
    always_comb begin
        wr_en   = axis_m_tvalid && ready_q;
        rd_en   = valid_q && axis_s_tready;
        rd_word = mem[rd_ptr_q];
        pkt_inc = wr_en && axis_m_tlast;
        pkt_dec = rd_en && rd_word[0];

        level_d = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + LVL_ONE;
        end else if (rd_en && !wr_en) begin
            level_d = level_q - LVL_ONE;
        end

        pkt_count_d = pkt_count_q;
        if (pkt_inc && !pkt_dec && pkt_count_q != DEPTH) begin
            pkt_count_d = pkt_count_q + LVL_ONE;
        end else if (pkt_dec && !pkt_inc && pkt_count_q != '0) begin
            pkt_count_d = pkt_count_q - LVL_ONE;
        end

        active_d = active_q;
        if (rd_en) begin
            active_d = !rd_word[0];
        end

        full_d  = (level_d == DEPTH);
        empty_d = (level_d == '0);
        ready_d = !full_d;

        // Full override lets packets longer than the FIFO degrade to cut-through;
        // active keeps valid up mid-packet once the gate has opened.
        if (STORE_FWD != 0) begin
            valid_d = !empty_d && ((pkt_count_d != '0) || full_d || active_d);
        end else begin
            valid_d = !empty_d;
        end
    end

    // Pointer, counter and registered flag state
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_count_q <= '0;
            active_q    <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q     <= level_d;
            pkt_count_q <= pkt_count_d;
            active_q    <= active_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {axis_m_tdata, axis_m_tkeep, axis_m_tlast};
        end
    end

    // Output word is zeroed whenever nothing is presented
    always_comb begin
        {axis_s_tdata, axis_s_tkeep, axis_s_tlast} = valid_q ? rd_word : '0;
        axis_s_tvalid = valid_q;
        axis_m_tready = ready_q;
        level         = level_q;
        pkt_count     = pkt_count_q;
        full          = full_q;
        empty         = empty_q;
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: one store-and-forward and one
// cut-through instance, each scenario in its own task.
module tb_axis_pkt_fifo;

    logic clk = 1'b0;
    logic reset_ = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] sf_m_tdata, sf_s_tdata, ct_m_tdata, ct_s_tdata;
    logic [7:0]  sf_m_tkeep, sf_s_tkeep, ct_m_tkeep, ct_s_tkeep;
    logic        sf_m_tlast, sf_m_tvalid, sf_m_tready, sf_s_tlast, sf_s_tvalid, sf_s_tready;
    logic        ct_m_tlast, ct_m_tvalid, ct_m_tready, ct_s_tlast, ct_s_tvalid, ct_s_tready;
    logic [5:0]  sf_level, sf_pkt_count, ct_level, ct_pkt_count;
    logic        sf_full, sf_empty, ct_full, ct_empty;

    always #5 clk = ~clk;

    axis_pkt_fifo #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .ADDR_WIDTH(5), .STORE_FWD(1)) u_sf (
        .clk(clk), .reset_(reset_),
        .axis_m_tdata(sf_m_tdata), .axis_m_tkeep(sf_m_tkeep), .axis_m_tlast(sf_m_tlast),
        .axis_m_tvalid(sf_m_tvalid), .axis_m_tready(sf_m_tready),
        .axis_s_tdata(sf_s_tdata), .axis_s_tkeep(sf_s_tkeep), .axis_s_tlast(sf_s_tlast),
        .axis_s_tvalid(sf_s_tvalid), .axis_s_tready(sf_s_tready),
        .level(sf_level), .pkt_count(sf_pkt_count), .full(sf_full), .empty(sf_empty)
    );

    axis_pkt_fifo #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .ADDR_WIDTH(5), .STORE_FWD(0)) u_ct (
        .clk(clk), .reset_(reset_),
        .axis_m_tdata(ct_m_tdata), .axis_m_tkeep(ct_m_tkeep), .axis_m_tlast(ct_m_tlast),
        .axis_m_tvalid(ct_m_tvalid), .axis_m_tready(ct_m_tready),
        .axis_s_tdata(ct_s_tdata), .axis_s_tkeep(ct_s_tkeep), .axis_s_tlast(ct_s_tlast),
        .axis_s_tvalid(ct_s_tvalid), .axis_s_tready(ct_s_tready),
        .level(ct_level), .pkt_count(ct_pkt_count), .full(ct_full), .empty(ct_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat to the store-and-forward instance for one edge
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        sf_m_tdata  = d;
        sf_m_tkeep  = k;
        sf_m_tlast  = l;
        sf_m_tvalid = 1'b1;
        tick();
        sf_m_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset_ = 1'b0;
        #5;
        checks++; if (sf_s_tvalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", sf_s_tvalid); end
        checks++; if (sf_m_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %0b exp 0", sf_m_tready); end
        checks++; if (sf_full !== 1'b0 || sf_empty !== 1'b1) begin errors++; $display("FAIL rst_flags got full=%0b empty=%0b exp 0/1", sf_full, sf_empty); end
        checks++; if (sf_level !== 6'd0 || sf_pkt_count !== 6'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", sf_level, sf_pkt_count); end
        checks++; if (sf_s_tdata !== 64'h0 || sf_s_tkeep !== 8'h0 || sf_s_tlast !== 1'b0) begin errors++; $display("FAIL rst_data got %0h exp 0", sf_s_tdata); end
        checks++; if (ct_s_tvalid !== 1'b0 || ct_empty !== 1'b1) begin errors++; $display("FAIL rst_ct got valid=%0b empty=%0b exp 0/1", ct_s_tvalid, ct_empty); end
        @(negedge clk) reset_ = 1'b1;
        tick();
        checks++; if (sf_m_tready !== 1'b1 || ct_m_tready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b/%0b exp 1/1", sf_m_tready, ct_m_tready); end
    endtask

    task automatic test_sf_packet();
        logic [63:0] d [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
        logic [7:0]  k [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};
        sf_s_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(d[i], k[i], i == 3);
            if (i < 3) begin
                checks++; if (sf_s_tvalid !== 1'b0) begin errors++; $display("FAIL sf_gate beat %0d got valid %0b exp 0", i, sf_s_tvalid); end
            end
        end
        checks++; if (sf_pkt_count !== 6'd1 || sf_level !== 6'd4) begin errors++; $display("FAIL sf_counts got %0d/%0d exp 1/4", sf_pkt_count, sf_level); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sf_s_tvalid !== 1'b1 || sf_s_tdata !== d[i] || sf_s_tkeep !== k[i] || sf_s_tlast !== (i == 3)) begin
                errors++; $display("FAIL sf_out beat %0d got v=%0b d=%0h k=%0h l=%0b exp d=%0h k=%0h", i, sf_s_tvalid, sf_s_tdata, sf_s_tkeep, sf_s_tlast, d[i], k[i]);
            end
            checks++; if (sf_pkt_count !== 6'd1) begin errors++; $display("FAIL sf_pkt_hold beat %0d got %0d exp 1", i, sf_pkt_count); end
            tick();
        end
        checks++; if (sf_level !== 6'd0 || sf_pkt_count !== 6'd0 || sf_s_tvalid !== 1'b0 || sf_empty !== 1'b1) begin
            errors++; $display("FAIL sf_end got lvl=%0d pkt=%0d v=%0b exp 0/0/0", sf_level, sf_pkt_count, sf_s_tvalid);
        end
    endtask

    task automatic test_cut_through();
        logic [63:0] d [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
        ct_s_tready = 1'b1;
        ct_m_tkeep  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            ct_m_tdata  = d[i];
            ct_m_tlast  = (i == 3);
            ct_m_tvalid = 1'b1;
            tick();
            checks++;
            if (ct_s_tvalid !== 1'b1 || ct_s_tdata !== d[i] || ct_s_tlast !== (i == 3)) begin
                errors++; $display("FAIL ct_out beat %0d got v=%0b d=%0h l=%0b exp d=%0h", i, ct_s_tvalid, ct_s_tdata, ct_s_tlast, d[i]);
            end
        end
        ct_m_tvalid = 1'b0;
        tick();
        checks++; if (ct_s_tvalid !== 1'b0 || ct_level !== 6'd0) begin errors++; $display("FAIL ct_end got v=%0b lvl=%0d exp 0/0", ct_s_tvalid, ct_level); end
    endtask

    task automatic test_full();
        sf_s_tready = 1'b0;
        for (int i = 0; i < 32; i++) send_beat(64'h100 + 64'(i), 8'hFF, 1'b1);
        checks++; if (sf_full !== 1'b1 || sf_m_tready !== 1'b0) begin errors++; $display("FAIL full_flag got full=%0b rdy=%0b exp 1/0", sf_full, sf_m_tready); end
        checks++; if (sf_level !== 6'd32 || sf_pkt_count !== 6'd32) begin errors++; $display("FAIL full_counts got %0d/%0d exp 32/32", sf_level, sf_pkt_count); end
        send_beat(64'hDEAD, 8'hFF, 1'b1);
        checks++; if (sf_level !== 6'd32) begin errors++; $display("FAIL full_no_write got lvl %0d exp 32", sf_level); end
        sf_s_tready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (sf_s_tvalid !== 1'b1 || sf_s_tdata !== 64'h100 + 64'(i) || sf_s_tlast !== 1'b1) begin
                errors++; $display("FAIL full_drain beat %0d got v=%0b d=%0h l=%0b exp d=%0h", i, sf_s_tvalid, sf_s_tdata, sf_s_tlast, 64'h100 + 64'(i));
            end
            if (i == 0) begin
                checks++; if (sf_m_tready !== 1'b0) begin errors++; $display("FAIL full_rd_same_cycle got rdy %0b exp 0", sf_m_tready); end
            end
            tick();
            if (i == 0) begin
                checks++; if (sf_m_tready !== 1'b1 || sf_level !== 6'd31) begin errors++; $display("FAIL full_ready_rise got rdy=%0b lvl=%0d exp 1/31", sf_m_tready, sf_level); end
            end
        end
        checks++; if (sf_empty !== 1'b1 || sf_pkt_count !== 6'd0 || sf_s_tvalid !== 1'b0) begin errors++; $display("FAIL full_end got e=%0b pkt=%0d v=%0b exp 1/0/0", sf_empty, sf_pkt_count, sf_s_tvalid); end
    endtask

    task automatic test_long_packet();
        int idx_w, idx_r, exp_pkt, cyc;
        logic wrote, read, rlast;
        sf_s_tready = 1'b0;
        for (int i = 0; i < 32; i++) send_beat(64'h200 + 64'(i), 8'hFF, 1'b0);
        checks++; if (sf_s_tvalid !== 1'b1 || sf_s_tdata !== 64'h200 || sf_pkt_count !== 6'd0) begin
            errors++; $display("FAIL long_override got v=%0b d=%0h pkt=%0d exp 1/200/0", sf_s_tvalid, sf_s_tdata, sf_pkt_count);
        end
        sf_s_tready = 1'b1;
        idx_w = 32; idx_r = 0; exp_pkt = 0; cyc = 0;
        while (idx_r < 40 && cyc < 200) begin
            sf_m_tvalid = (idx_w < 40);
            sf_m_tdata  = 64'h200 + 64'(idx_w);
            sf_m_tkeep  = 8'hFF;
            sf_m_tlast  = (idx_w == 39);
            checks++; if (sf_pkt_count !== 6'(exp_pkt)) begin errors++; $display("FAIL long_pkt cyc %0d got %0d exp %0d", cyc, sf_pkt_count, exp_pkt); end
            checks++;
            if (sf_s_tvalid !== 1'b1 || sf_s_tdata !== 64'h200 + 64'(idx_r) || sf_s_tlast !== (idx_r == 39)) begin
                errors++; $display("FAIL long_out beat %0d got v=%0b d=%0h l=%0b", idx_r, sf_s_tvalid, sf_s_tdata, sf_s_tlast);
            end
            wrote = sf_m_tvalid && sf_m_tready;
            read  = sf_s_tvalid;
            rlast = (idx_r == 39);
            tick();
            if (wrote) idx_w++;
            if (read) idx_r++;
            if (wrote && sf_m_tlast) exp_pkt++;
            if (read && rlast) exp_pkt--;
            cyc++;
        end
        sf_m_tvalid = 1'b0;
        checks++; if (idx_r != 40) begin errors++; $display("FAIL long_timeout got %0d beats exp 40", idx_r); end
        checks++; if (sf_level !== 6'd0 || sf_pkt_count !== 6'd0 || sf_s_tvalid !== 1'b0) begin errors++; $display("FAIL long_end got lvl=%0d pkt=%0d v=%0b", sf_level, sf_pkt_count, sf_s_tvalid); end
    endtask

    task automatic test_simultaneous();
        sf_s_tready = 1'b0;
        send_beat(64'h301, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(64'h310 + 64'(i), 8'hFF, 1'b0);
        checks++; if (sf_level !== 6'd5 || sf_pkt_count !== 6'd1 || sf_s_tdata !== 64'h301) begin
            errors++; $display("FAIL sim_setup got lvl=%0d pkt=%0d d=%0h exp 5/1/301", sf_level, sf_pkt_count, sf_s_tdata);
        end
        sf_s_tready = 1'b1;
        send_beat(64'h314, 8'hFF, 1'b1);
        checks++; if (sf_level !== 6'd5 || sf_pkt_count !== 6'd1) begin errors++; $display("FAIL sim_hold got lvl=%0d pkt=%0d exp 5/1", sf_level, sf_pkt_count); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sf_s_tvalid !== 1'b1 || sf_s_tdata !== 64'h310 + 64'(i) || sf_s_tlast !== (i == 4)) begin
                errors++; $display("FAIL sim_drain beat %0d got v=%0b d=%0h l=%0b", i, sf_s_tvalid, sf_s_tdata, sf_s_tlast);
            end
            tick();
        end
        checks++; if (sf_empty !== 1'b1 || sf_pkt_count !== 6'd0) begin errors++; $display("FAIL sim_end got e=%0b pkt=%0d exp 1/0", sf_empty, sf_pkt_count); end
    endtask

    task automatic test_reset_mid();
        sf_s_tready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(64'h401 + 64'(i), 8'hFF, i == 2);
        for (int i = 0; i < 4; i++) send_beat(64'h410 + 64'(i), 8'hFF, 1'b0);
        checks++; if (sf_level !== 6'd7 || sf_s_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_setup got lvl=%0d v=%0b exp 7/1", sf_level, sf_s_tvalid); end
        #3 reset_ = 1'b0;
        #1;
        checks++; if (sf_s_tvalid !== 1'b0 || sf_level !== 6'd0 || sf_pkt_count !== 6'd0 || sf_empty !== 1'b1) begin
            errors++; $display("FAIL rmid_async got v=%0b lvl=%0d pkt=%0d e=%0b exp 0/0/0/1", sf_s_tvalid, sf_level, sf_pkt_count, sf_empty);
        end
        @(posedge clk);
        #3 reset_ = 1'b1;
        tick();
        checks++; if (sf_m_tready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0b exp 1", sf_m_tready); end
        sf_s_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(64'hA0 + 64'(i), 8'hFF, i == 3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sf_s_tvalid !== 1'b1 || sf_s_tdata !== 64'hA0 + 64'(i) || sf_s_tlast !== (i == 3)) begin
                errors++; $display("FAIL rmid_out beat %0d got v=%0b d=%0h l=%0b", i, sf_s_tvalid, sf_s_tdata, sf_s_tlast);
            end
            tick();
        end
        checks++; if (sf_empty !== 1'b1 || sf_s_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_end got e=%0b v=%0b exp 1/0", sf_empty, sf_s_tvalid); end
    endtask

    initial begin
        sf_m_tdata = '0; sf_m_tkeep = '0; sf_m_tlast = 1'b0; sf_m_tvalid = 1'b0; sf_s_tready = 1'b0;
        ct_m_tdata = '0; ct_m_tkeep = '0; ct_m_tlast = 1'b0; ct_m_tvalid = 1'b0; ct_s_tready = 1'b0;
        test_reset();
        test_sf_packet();
        test_cut_through();
        test_full();
        test_long_packet();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
